// File: rtl/serial_word_collector_if.sv
// Serial-in / word-out bus between the bit-select mux, the collector and the
// next lab stage.
//   in_bit, in_en  : qualified serial bit stream into the collector
//   out_ready      : consumer accepts the held word
//   out_word       : assembled word, LSB received first
//   out_valid      : out_word / parity_err are valid
//   parity_err     : even-parity violation for the held word
//   overrun        : sticky flag, a start marker was dropped while a word was held
//   busy           : a frame is being received
interface serial_word_collector_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_bit;
  logic             in_en;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             parity_err;
  logic             overrun;
  logic             busy;

  // Producer/consumer side: drives the bit stream and the ready.
  modport master (
    output in_bit,
    output in_en,
    output out_ready,
    input  out_word,
    input  out_valid,
    input  parity_err,
    input  overrun,
    input  busy
  );

  // Collector side.
  modport slave (
    input  in_bit,
    input  in_en,
    input  out_ready,
    output out_word,
    output out_valid,
    output parity_err,
    output overrun,
    output busy
  );

endinterface

// File: rtl/serial_word_collector.sv
// Deserializer behind the 2:1 bit-select mux. Frames qualified bits as
// start marker (1), WIDTH data bits LSB first, one even-parity bit, and holds
// each completed word behind a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_word_collector_if.slave (in_bit, in_en, out_ready in;
//           out_word, out_valid, parity_err, overrun, busy out, all registered)
module serial_word_collector #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_word_collector_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;
  logic               marker;

  assign marker = bus.in_en & bus.in_bit;

  // Register bank, synchronous reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;

    case (state_q)
      IDLE: begin
        if (marker) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (bus.in_en) begin
          shreg_d[cnt_q] = bus.in_bit;
          // Counter holds at WIDTH-1 instead of wrapping on the last data bit.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bus.in_en) begin
          word_d  = shreg_q;
          perr_d  = (^shreg_q) ^ bus.in_bit;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          // A marker on the handshake cycle starts the next frame at once.
          if (marker) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (marker) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT) || (state_d == PARITY);
  end

  assign bus.out_word   = word_q;
  assign bus.out_valid  = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Randomized and directed bench for serial_word_collector against a
// frame-level reference model.
module tb_serial_word_collector;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   cyc_no;

  serial_word_collector_if #(.WIDTH(W)) bus ();

  serial_word_collector #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame progress as a count of data bits received.
  logic [W-1:0] m_word;
  logic         m_valid;
  logic         m_perr;
  logic         m_ovr;
  bit           m_in_frame;
  int           m_pos;
  logic [W-1:0] m_acc;

  int           vq[$];
  logic [W-1:0] wq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic model_start();
    m_in_frame = 1'b1;
    m_pos      = 0;
    m_acc      = '0;
  endtask

  task automatic model_update(input logic r, input logic e, input logic b, input logic rd);
    if (!r) begin
      m_word = '0; m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
      m_in_frame = 1'b0; m_pos = 0; m_acc = '0;
    end else if (m_valid) begin
      if (rd) begin
        m_valid = 1'b0;
        if (e && b) model_start();
      end else if (e && b) begin
        m_ovr = 1'b1;
      end
    end else if (!m_in_frame) begin
      if (e && b) model_start();
    end else if (e) begin
      if (m_pos < int'(W)) begin
        if (b) m_acc = m_acc + W'(1 << m_pos);
        m_pos++;
      end else begin
        m_word     = m_acc;
        m_perr     = ((int'($countones(m_acc)) + int'(b)) % 2) != 0;
        m_valid    = 1'b1;
        m_in_frame = 1'b0;
      end
    end
  endtask

  // One clock: drive at negedge, model on posedge, compare 1 time unit later.
  task automatic cyc(input logic r, input logic e, input logic b, input logic rd);
    @(negedge clk);
    rst_n         = r;
    bus.in_en     = e;
    bus.in_bit    = b;
    bus.out_ready = rd;
    @(posedge clk);
    model_update(r, e, b, rd);
    #1;
    cyc_no++;
    check("out_word",   32'(bus.out_word),   32'(m_word));
    check("out_valid",  32'(bus.out_valid),  32'(m_valid));
    check("parity_err", 32'(bus.parity_err), 32'(m_perr));
    check("overrun",    32'(bus.overrun),    32'(m_ovr));
    check("busy",       32'(bus.busy),       32'(m_in_frame));
    if (bus.out_valid === 1'b1) begin
      vq.push_back(cyc_no);
      wq.push_back(bus.out_word);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic bad_par,
                            input logic gaps, input logic rd);
    logic [W+1:0] bits;
    bits = {(^d) ^ bad_par, d, 1'b1};
    for (int i = 0; i < int'(W) + 2; i++) begin
      cyc(1'b1, 1'b1, bits[i], rd);
      if (gaps) cyc(1'b1, 1'b0, 1'b0, rd);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc_no = 0;
    rst_n = 1'b0; bus.in_en = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b0;
    m_word = '0; m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
    m_in_frame = 1'b0; m_pos = 0; m_acc = '0;

    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_word",  32'(bus.out_word),  32'd0);

    // 0xA5 with good parity; valid visible right after the parity edge.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check("a5_word",  32'(bus.out_word),   32'hA5);
    check("a5_perr",  32'(bus.parity_err), 32'd0);
    check("a5_valid", 32'(bus.out_valid),  32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("a5_accept", 32'(bus.out_valid), 32'd0);

    // Bad parity.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("bad_word", 32'(bus.out_word),   32'hA5);
    check("bad_perr", 32'(bus.parity_err), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);

    // Gapped frame must match the gap-free result.
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check("gap_word", 32'(bus.out_word),   32'h3C);
    check("gap_perr", 32'(bus.parity_err), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure: marker while a word is held is dropped and flagged.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("ovr_set",  32'(bus.overrun),  32'd1);
    check("ovr_word", 32'(bus.out_word), 32'hA5);
    check("ovr_hold", 32'(bus.out_valid), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("ovr_accept", 32'(bus.out_valid), 32'd0);
    check("ovr_sticky", 32'(bus.overrun),   32'd1);

    // Back-to-back frames with out_ready high.
    vq.delete(); wq.delete();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("b2b_count", 32'(vq.size()), 32'd2);
    if (vq.size() == 2) begin
      check("b2b_word0", 32'(wq[0]), 32'h0F);
      check("b2b_word1", 32'(wq[1]), 32'hF0);
      check("b2b_gap",   32'(vq[1] - vq[0]), 32'(W + 2));
    end

    // Reset mid-frame, then a clean frame.
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'(i % 2), 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("mid_busy",  32'(bus.busy),    32'd0);
    check("mid_ovr",   32'(bus.overrun), 32'd0);
    check("mid_word",  32'(bus.out_word), 32'd0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    check("w81_word", 32'(bus.out_word),   32'h81);
    check("w81_perr", 32'(bus.parity_err), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);

    // Idle noise.
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_busy",  32'(bus.busy),      32'd0);
    check("idle_valid", 32'(bus.out_valid), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 9) < 7),
          1'($urandom),
          ($urandom_range(0, 9) < 6));
    end

    // Random well-formed frames with random parity and gaps.
    for (int i = 0; i < 60; i++) begin
      send_frame(W'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom), 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Deserializer stage directly downstream of the lab 2:1 bit-select mux. It samples the mux's 1-bit output on qualified cycles, frames it with a start marker and an even-parity bit, and assembles WIDTH-bit words. Completed words are presented with a valid/ready handshake, and the block flags parity errors and overruns. It turns the mux's combinational bit stream into word-level data for the next lab stage.

## Interface
- WIDTH, 8, data bits per frame; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- in_bit  input  1  serial data, driven by the mux output.
- in_en  input  1  qualifier; in_bit is sampled only on cycles with in_en=1.
- out_ready  input  1  consumer accepts the word on a cycle with out_valid=1 and out_ready=1.
- out_word  output  WIDTH  assembled word, LSB received first.
- out_valid  output  1  out_word and parity_err are valid.
- parity_err  output  1  parity error for the held word; qualified by out_valid.
- overrun  output  1  sticky: a start marker was lost while a word was held.
- busy  output  1  high in SHIFT and PARITY.

## Operation
- All registers update on rising clk. rst_n=0 at an edge forces the following on that edge, regardless of current state or in-flight frame; any partial frame is discarded:
  - state=IDLE, bit counter=0, shift register=0;
  - out_word=0, out_valid=0, parity_err=0, overrun=0, busy=0.
- A qualified bit is in_bit on a cycle with in_en=1. Cycles with in_en=0 never advance state or the counter. Gaps of any length are legal anywhere in a frame.
- Frame format, in qualified bits: a start marker (1'b1), then WIDTH data bits LSB first, then one parity bit. The parity bit makes the count of ones over data+parity even.
- In IDLE, a qualified 0 is idle line and is ignored.
- States and transitions:
  - IDLE: on a qualified 1, go to SHIFT and clear the counter.
  - SHIFT: each qualified bit is written into bit position [counter], then the counter increments. After data bit WIDTH-1, go to PARITY.
  - PARITY: on the qualified parity bit:
    - out_word <= shift register;
    - parity_err <= (XOR of data bits) ^ parity bit;
    - out_valid <= 1;
    - go to DONE.
  - DONE: hold out_word, parity_err and out_valid=1 until out_ready=1.
    - On the handshake cycle, clear out_valid the next cycle.
    - If that same cycle also carries a qualified 1, go directly to SHIFT (back-to-back frames). Otherwise go to IDLE.
- In DONE with out_ready=0:
  - a qualified 1 sets overrun=1 and the marker is dropped; the held word is unchanged;
  - a qualified 0 is ignored.
- overrun clears only on reset.
- out_word changes only on the PARITY capture edge or on reset.
- The counter is ceil(log2(WIDTH)) bits wide and never wraps within a frame. The SHIFT to PARITY transition is decoded at counter==WIDTH-1.

## Timing
- Latency: out_valid rises on the clock edge that samples the parity bit, so it is visible the cycle after the parity bit is presented.
- Minimum frame is WIDTH+2 cycles with in_en held high. Back-to-back throughput is one frame per WIDTH+2 qualified cycles, provided out_ready=1 when the next marker arrives.
- out_valid may assert with out_ready already high; the word is then accepted on the first valid cycle and out_valid is high for exactly one cycle.
- out_valid never drops without a handshake, except on reset.
- busy is high from the edge that samples the marker through the edge that samples the parity bit, exclusive. It is registered.
- No combinational path from any input to any output.

## Test plan
- Reset then frame, WIDTH=8, in_en=1 continuously: bits 1, then 1,0,1,0,0,1,0,1, then parity 0 -> out_word=0xA5, parity_err=0, out_valid one cycle after the parity bit.
- Same frame with parity bit 1 -> out_word=0xA5, parity_err=1. Then send 0x3C with in_en toggling 1/0 every cycle -> out_word=0x3C, parity_err=0, identical to the gap-free result.
- Backpressure: hold out_ready=0 after the 0xA5 frame, then send a qualified 1 -> overrun=1 and out_word stays 0xA5. Raise out_ready -> out_valid falls next cycle, and overrun stays 1.
- Back-to-back: out_ready=1, a 0x0F frame immediately followed by a 0xF0 frame with no idle bits -> two words 0x0F then 0xF0, each out_valid for one cycle, WIDTH+2 cycles apart.
- Reset mid-frame: rst_n=0 for one cycle after 4 data bits -> all outputs 0, state IDLE. A following full 0x81 frame yields out_word=0x81, parity_err=0.
- Idle noise: 20 qualified 0s in IDLE -> busy=0, out_valid=0, no state change.
